// File: rtl/store_split_if.sv
// Store request and half-word memory write bus seen by store_split_unit.
// The unit uses the slave view; the requesting side uses the master view.
interface store_split_if;
  logic        mem_write_i;
  logic [1:0]  store_size_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        mem_ready_i;
  logic [31:0] data_mem_addr_o;
  logic [15:0] data_mem_wdata_o;
  logic        data_mem_we_o;
  logic [1:0]  data_mem_be_o;
  logic        stall_o;
  logic        align_err_o;

  modport slave (
    input  mem_write_i, store_size_i, addr_i, data_i, mem_ready_i,
    output data_mem_addr_o, data_mem_wdata_o, data_mem_we_o, data_mem_be_o,
           stall_o, align_err_o
  );

  modport master (
    output mem_write_i, store_size_i, addr_i, data_i, mem_ready_i,
    input  data_mem_addr_o, data_mem_wdata_o, data_mem_we_o, data_mem_be_o,
           stall_o, align_err_o
  );
endinterface

// File: rtl/store_split_unit.sv
// Splits a byte/half/word store into one or two half-word write beats
// (low half first) and stalls the pipeline while beats are outstanding.
module store_split_unit (
  input  logic         clk_i,
  input  logic         rst_i,
  store_split_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    W_LOW  = 2'd1,
    W_HIGH = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [1:0]  size_r;
  logic [31:0] mem_addr_r;
  logic [15:0] mem_wdata_r;
  logic        mem_we_r;
  logic [1:0]  mem_be_r;
  logic        align_err_r;

  logic        legal_s;
  logic        last_beat_s;
  logic        free_s;
  logic        accept_s;
  logic        reject_s;
  logic        stall_s;

  function automatic logic [15:0] low_wdata(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: low_wdata = {data[7:0], data[7:0]};
      default: low_wdata = data[15:0];
    endcase
  endfunction

  function automatic logic [1:0] low_be(input logic [1:0] size, input logic addr0);
    case (size)
      SZ_BYTE: low_be = addr0 ? 2'b10 : 2'b01;
      default: low_be = 2'b11;
    endcase
  endfunction

  // Request legality, acceptance window and the stall decode
  always_comb begin
    legal_s     = 1'b0;
    last_beat_s = 1'b0;
    case (bus.store_size_i)
      SZ_BYTE: legal_s = 1'b1;
      SZ_HALF: legal_s = ~bus.addr_i[0];
      SZ_WORD: legal_s = ~bus.addr_i[0];
      default: legal_s = 1'b0;
    endcase
    case (state_r)
      W_LOW:   last_beat_s = (size_r != SZ_WORD);
      W_HIGH:  last_beat_s = 1'b1;
      default: last_beat_s = 1'b0;
    endcase
    // The unit can take a new request on the edge that retires the final beat.
    if (state_r == IDLE) begin
      free_s = 1'b1;
    end else begin
      free_s = last_beat_s & bus.mem_ready_i;
    end
    accept_s = free_s & bus.mem_write_i & legal_s;
    reject_s = free_s & bus.mem_write_i & ~legal_s;
    stall_s  = (state_r != IDLE) & ~(last_beat_s & bus.mem_ready_i);
  end

  // Beat sequencer: captures requests and registers every memory-side output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      addr_r      <= 32'd0;
      data_r      <= 32'd0;
      size_r      <= 2'b00;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 16'd0;
      mem_we_r    <= 1'b0;
      mem_be_r    <= 2'b00;
      align_err_r <= 1'b0;
    end else begin
      align_err_r <= reject_s;
      if (accept_s) begin
        state_r     <= W_LOW;
        addr_r      <= bus.addr_i;
        data_r      <= bus.data_i;
        size_r      <= bus.store_size_i;
        mem_addr_r  <= {bus.addr_i[31:1], 1'b0};
        mem_wdata_r <= low_wdata(bus.store_size_i, bus.data_i);
        mem_be_r    <= low_be(bus.store_size_i, bus.addr_i[0]);
        mem_we_r    <= 1'b1;
      end else begin
        case (state_r)
          W_LOW: begin
            if (bus.mem_ready_i && (size_r == SZ_WORD)) begin
              state_r     <= W_HIGH;
              mem_addr_r  <= {addr_r[31:1], 1'b0} + 32'd2;
              mem_wdata_r <= data_r[31:16];
              mem_be_r    <= 2'b11;
              mem_we_r    <= 1'b1;
            end else if (bus.mem_ready_i) begin
              state_r     <= IDLE;
              mem_addr_r  <= 32'd0;
              mem_wdata_r <= 16'd0;
              mem_be_r    <= 2'b00;
              mem_we_r    <= 1'b0;
            end else begin
              state_r     <= W_LOW;
            end
          end
          W_HIGH: begin
            if (bus.mem_ready_i) begin
              state_r     <= IDLE;
              mem_addr_r  <= 32'd0;
              mem_wdata_r <= 16'd0;
              mem_be_r    <= 2'b00;
              mem_we_r    <= 1'b0;
            end else begin
              state_r     <= W_HIGH;
            end
          end
          default: begin
            state_r     <= IDLE;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 16'd0;
            mem_be_r    <= 2'b00;
            mem_we_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_mem_addr_o  = mem_addr_r;
  assign bus.data_mem_wdata_o = mem_wdata_r;
  assign bus.data_mem_we_o    = mem_we_r;
  assign bus.data_mem_be_o    = mem_be_r;
  assign bus.stall_o          = stall_s;
  assign bus.align_err_o      = align_err_r;

endmodule

// File: tb/tb_store_split_unit.sv
// Bench for store_split_unit: queue-of-beats reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_store_split_unit;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;
  beat_t q[$];
  logic exp_err = 1'b0;
  int   beat_cnt;

  store_split_if bus();

  store_split_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted store becomes its list of beats; a beat leaves
  // the list on any edge where the memory is ready.
  always @(posedge clk) begin
    logic [1:0]  sz;
    logic [31:0] a, d, base;
    if (rst) begin
      q.delete();
      exp_err = 1'b0;
    end else begin
      if (q.size() != 0 && bus.mem_ready_i) void'(q.pop_front());
      exp_err = 1'b0;
      if (q.size() == 0 && bus.mem_write_i) begin
        sz   = bus.store_size_i;
        a    = bus.addr_i;
        d    = bus.data_i;
        base = {a[31:1], 1'b0};
        if (sz == 2'b00)
          q.push_back('{base, {d[7:0], d[7:0]}, a[0] ? 2'b10 : 2'b01});
        else if (sz == 2'b01 && !a[0])
          q.push_back('{base, d[15:0], 2'b11});
        else if (sz == 2'b10 && !a[0]) begin
          q.push_back('{base, d[15:0], 2'b11});
          q.push_back('{base + 32'd2, d[31:16], 2'b11});
        end else
          exp_err = 1'b1;
      end
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    beat_t f;
    logic  busy;
    if (chk_en) begin
      busy = (q.size() != 0);
      if (busy) f = q[0];
      else f = '{32'd0, 16'd0, 2'b00};
      check("m_we",    {31'd0, bus.data_mem_we_o}, {31'd0, busy});
      check("m_addr",  bus.data_mem_addr_o, f.addr);
      check("m_wdata", {16'd0, bus.data_mem_wdata_o}, {16'd0, f.wdata});
      check("m_be",    {30'd0, bus.data_mem_be_o}, {30'd0, f.be});
      check("m_stall", {31'd0, bus.stall_o},
            {31'd0, busy && !(q.size() == 1 && bus.mem_ready_i)});
      check("m_err",   {31'd0, bus.align_err_o}, {31'd0, exp_err});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.mem_write_i  = 1'b1;
    bus.store_size_i = sz;
    bus.addr_i       = a;
    bus.data_i       = d;
  endtask

  task automatic lit(input string name, input logic [31:0] addr, input logic [15:0] wd,
                     input logic [1:0] be, input logic we, input logic st);
    check({name, "_addr"},  bus.data_mem_addr_o, addr);
    check({name, "_wdata"}, {16'd0, bus.data_mem_wdata_o}, {16'd0, wd});
    check({name, "_be"},    {30'd0, bus.data_mem_be_o}, {30'd0, be});
    check({name, "_we"},    {31'd0, bus.data_mem_we_o}, {31'd0, we});
    check({name, "_stall"}, {31'd0, bus.stall_o}, {31'd0, st});
  endtask

  initial begin
    bus.mem_write_i  = 1'b0;
    bus.store_size_i = 2'b00;
    bus.addr_i       = 32'd0;
    bus.data_i       = 32'd0;
    bus.mem_ready_i  = 1'b1;
    rst = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    lit("reset", 32'd0, 16'd0, 2'b00, 1'b0, 1'b0);
    check("reset_err", {31'd0, bus.align_err_o}, 32'd0);
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // Word store with ready high
    drive(2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
    @(negedge clk); check("w_acc_stall", {31'd0, bus.stall_o}, 32'd0);
    cyc(); bus.mem_write_i = 1'b0;
    @(negedge clk); lit("w_lo", 32'h100, 16'hBEEF, 2'b11, 1'b1, 1'b1);
    cyc();
    @(negedge clk); lit("w_hi", 32'h102, 16'hDEAD, 2'b11, 1'b1, 1'b0);
    cyc();
    @(negedge clk); lit("w_done", 32'd0, 16'd0, 2'b00, 1'b0, 1'b0);

    // Byte stores at odd and even addresses
    cyc(); drive(2'b00, 32'h0000_0201, 32'h0000_005A);
    cyc(); bus.mem_write_i = 1'b0;
    @(negedge clk); lit("b_odd", 32'h200, 16'h5A5A, 2'b10, 1'b1, 1'b0);
    cyc(); drive(2'b00, 32'h0000_0200, 32'h0000_005A);
    cyc(); bus.mem_write_i = 1'b0;
    @(negedge clk); lit("b_even", 32'h200, 16'h5A5A, 2'b01, 1'b1, 1'b0);

    // Back-pressure: 3 stalled low-beat cycles, 1 stalled high-beat cycle
    cyc(); drive(2'b10, 32'h0000_0300, 32'h1234_5678);
    bus.mem_ready_i = 1'b0;
    cyc(); bus.mem_write_i = 1'b0;
    beat_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); lit("bp_lo_hold", 32'h300, 16'h5678, 2'b11, 1'b1, 1'b1);
      beat_cnt++;
      cyc();
    end
    bus.mem_ready_i = 1'b1;
    @(negedge clk); lit("bp_lo_go", 32'h300, 16'h5678, 2'b11, 1'b1, 1'b1);
    beat_cnt++;
    cyc(); bus.mem_ready_i = 1'b0;
    @(negedge clk); lit("bp_hi_hold", 32'h302, 16'h1234, 2'b11, 1'b1, 1'b1);
    beat_cnt++;
    cyc(); bus.mem_ready_i = 1'b1;
    @(negedge clk); lit("bp_hi_go", 32'h302, 16'h1234, 2'b11, 1'b1, 1'b0);
    beat_cnt++;
    cyc();
    @(negedge clk);
    if (bus.data_mem_we_o) beat_cnt++;
    check("bp_beats", beat_cnt, 32'd6);

    // Illegal requests: misaligned word, reserved size
    cyc(); drive(2'b10, 32'h0000_0103, 32'hFFFF_FFFF);
    @(negedge clk); check("mis_stall", {31'd0, bus.stall_o}, 32'd0);
    cyc(); bus.mem_write_i = 1'b0;
    @(negedge clk); check("mis_err", {31'd0, bus.align_err_o}, 32'd1);
    lit("mis", 32'd0, 16'd0, 2'b00, 1'b0, 1'b0);
    cyc(); drive(2'b11, 32'h0000_0100, 32'h1111_2222);
    @(negedge clk); check("rsv_err_clear", {31'd0, bus.align_err_o}, 32'd0);
    cyc(); bus.mem_write_i = 1'b0;
    @(negedge clk); check("rsv_err", {31'd0, bus.align_err_o}, 32'd1);
    lit("rsv", 32'd0, 16'd0, 2'b00, 1'b0, 1'b0);
    cyc();
    @(negedge clk); check("rsv_err_end", {31'd0, bus.align_err_o}, 32'd0);

    // Wrap-around word then back-to-back half-word
    cyc(); drive(2'b10, 32'hFFFF_FFFE, 32'hAABB_CCDD);
    cyc(); bus.mem_write_i = 1'b0;
    @(negedge clk); lit("wr_lo", 32'hFFFF_FFFE, 16'hCCDD, 2'b11, 1'b1, 1'b1);
    cyc(); drive(2'b01, 32'h0000_0010, 32'h0000_1357);
    @(negedge clk); lit("wr_hi", 32'h0000_0000, 16'hAABB, 2'b11, 1'b1, 1'b0);
    cyc(); bus.mem_write_i = 1'b0;
    @(negedge clk); lit("b2b_half", 32'h10, 16'h1357, 2'b11, 1'b1, 1'b0);

    // Reset in the high beat of a word, then a fresh store
    cyc(); drive(2'b10, 32'h0000_0400, 32'hCAFE_F00D);
    cyc(); bus.mem_write_i = 1'b0;
    cyc(); rst = 1'b1;
    @(negedge clk); lit("rs_hi", 32'h402, 16'hCAFE, 2'b11, 1'b1, 1'b0);
    cyc(); rst = 1'b0;
    @(negedge clk); lit("rs_after", 32'd0, 16'd0, 2'b00, 1'b0, 1'b0);
    drive(2'b00, 32'h0000_0401, 32'h0000_00C3);
    cyc(); bus.mem_write_i = 1'b0;
    @(negedge clk); lit("rs_new", 32'h400, 16'hC3C3, 2'b10, 1'b1, 1'b0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      cyc();
      rst              = ($urandom_range(0, 99) == 0);
      bus.mem_ready_i  = ($urandom_range(0, 3) != 0);
      bus.mem_write_i  = ($urandom_range(0, 2) == 0);
      bus.store_size_i = 2'($urandom_range(0, 3));
      bus.data_i       = $urandom;
      case ($urandom_range(0, 3))
        0:       bus.addr_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       bus.addr_i = $urandom;
        default: bus.addr_i = $urandom & 32'hFFFF_FFFE;
      endcase
    end
    cyc();
    rst = 1'b0;
    bus.mem_write_i = 1'b0;
    bus.mem_ready_i = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    check("drain_we", {31'd0, bus.data_mem_we_o}, 32'd0);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
